// File: rtl/cpu_ram_arbiter.sv
// Arbiter between the V33 CPU bus and the byte-wide high-score port for the 32K x 16 work RAM.
// Optional stall statistics counter is built when CPU_RAM_ARB_STATS_EN is defined.
module cpu_ram_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int MIN_GAP = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
`ifdef CPU_RAM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       stall_cycles,
`endif
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    input  logic              cpu_we_lo,
    input  logic              cpu_we_hi,
    output logic [15:0]       cpu_dout,
    output logic              cpu_stall,
    input  logic              hs_req,
    input  logic              hs_wr,
    input  logic [ADDR_W:0]   hs_addr,
    input  logic [7:0]        hs_din,
    output logic [7:0]        hs_dout,
    output logic              hs_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic              ram_we_lo,
    output logic              ram_we_hi,
    input  logic [15:0]       ram_q
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STALL   = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESTORE = 3'd4
    } state_t;

    // Loaded with MIN_GAP-1 so that exactly MIN_GAP IDLE cycles elapse before the next STALL.
    localparam logic [3:0] GAP_RELOAD = 4'(MIN_GAP - 1);

    state_t      r_state;
    logic [3:0]  r_gap;
    logic        r_stall;
    logic        r_ack;
    logic        r_rd_pend;
    logic        r_lane;
    logic [7:0]  r_hs_dout;
    logic [7:0]  w_rd_byte;

    // Access sequencer: state, gap counter and the registered handshake/stall outputs.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_gap     <= 4'd0;
            r_stall   <= 1'b0;
            r_ack     <= 1'b0;
            r_rd_pend <= 1'b0;
            r_lane    <= 1'b0;
            r_hs_dout <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (r_gap != 4'd0) begin
                        r_gap <= r_gap - 4'd1;
                    end
                    if (hs_req && (r_gap == 4'd0)) begin
                        r_state <= S_STALL;
                        r_stall <= 1'b1;
                    end else begin
                        r_stall <= 1'b0;
                    end
                end
                S_STALL: begin
                    r_stall <= 1'b1;
                    if (hs_req) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_state <= S_RESTORE;
                    end
                end
                S_ACCESS: begin
                    r_state   <= S_CAPTURE;
                    r_ack     <= 1'b1;
                    r_rd_pend <= ~hs_wr;
                    r_lane    <= hs_addr[0];
                end
                S_CAPTURE: begin
                    r_state <= S_RESTORE;
                    r_ack   <= 1'b0;
                    if (r_rd_pend) begin
                        r_hs_dout <= w_rd_byte;
                    end
                    r_rd_pend <= 1'b0;
                end
                S_RESTORE: begin
                    r_state <= S_IDLE;
                    r_stall <= 1'b0;
                    r_gap   <= GAP_RELOAD;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_stall   <= 1'b0;
                    r_ack     <= 1'b0;
                    r_rd_pend <= 1'b0;
                end
            endcase
        end
    end

    // RAM port steering: high-score owns the port only in ACCESS, CPU writes are gated by the stall.
    always_comb begin
        w_rd_byte = r_lane ? ram_q[15:8] : ram_q[7:0];
        if (r_state == S_ACCESS) begin
            ram_addr  = hs_addr[ADDR_W:1];
            ram_din   = {hs_din, hs_din};
            ram_we_lo = hs_wr & ~hs_addr[0];
            ram_we_hi = hs_wr & hs_addr[0];
        end else begin
            ram_addr  = cpu_addr;
            ram_din   = cpu_din;
            ram_we_lo = cpu_we_lo & ~r_stall;
            ram_we_hi = cpu_we_hi & ~r_stall;
        end
        // Forward the read byte during the ack cycle so hs_dout is valid together with hs_ack.
        if ((r_state == S_CAPTURE) && r_rd_pend) begin
            hs_dout = w_rd_byte;
        end else begin
            hs_dout = r_hs_dout;
        end
    end

    assign cpu_dout  = ram_q;
    assign cpu_stall = r_stall;
    assign hs_ack    = r_ack;

`ifdef CPU_RAM_ARB_STATS_EN
    logic [15:0] r_stall_cycles;

    // Saturating count of cycles in which the CPU was held off.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_stall_cycles <= 16'd0;
        end else if (stats_clr) begin
            r_stall_cycles <= 16'd0;
        end else if (r_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Self-checking bench for cpu_ram_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model with its own copy of the RAM contents.
module tb_cpu_ram_arbiter;

    localparam int ADDR_W  = 15;
    localparam int MIN_GAP = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [14:0] cpu_addr = 15'd0;
    logic [15:0] cpu_din = 16'd0;
    logic        cpu_we_lo = 1'b0;
    logic        cpu_we_hi = 1'b0;
    logic [15:0] cpu_dout;
    logic        cpu_stall;
    logic        hs_req = 1'b0;
    logic        hs_wr = 1'b0;
    logic [15:0] hs_addr = 16'd0;
    logic [7:0]  hs_din = 8'd0;
    logic [7:0]  hs_dout;
    logic        hs_ack;
    logic [14:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we_lo;
    logic        ram_we_hi;
    logic [15:0] ram_q = 16'd0;
`ifdef CPU_RAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] stall_cycles;
`endif

    cpu_ram_arbiter #(.ADDR_W(ADDR_W), .MIN_GAP(MIN_GAP)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
`ifdef CPU_RAM_ARB_STATS_EN
        .stats_clr    (stats_clr),
        .stall_cycles (stall_cycles),
`endif
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_we_lo (cpu_we_lo),
        .cpu_we_hi (cpu_we_hi),
        .cpu_dout  (cpu_dout),
        .cpu_stall (cpu_stall),
        .hs_req    (hs_req),
        .hs_wr     (hs_wr),
        .hs_addr   (hs_addr),
        .hs_din    (hs_din),
        .hs_dout   (hs_dout),
        .hs_ack    (hs_ack),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we_lo (ram_we_lo),
        .ram_we_hi (ram_we_hi),
        .ram_q     (ram_q)
    );

    always #5 clk_sys = ~clk_sys;

    // Two byte-lane synchronous RAMs (read-old-data), with a bench load port for preloading.
    logic [7:0]  mem_lo [0:32767];
    logic [7:0]  mem_hi [0:32767];
    logic        ld_en = 1'b0;
    logic [14:0] ld_addr = 15'd0;
    logic [15:0] ld_data = 16'd0;

    always @(posedge clk_sys) begin
        if (ld_en) begin
            mem_lo[ld_addr] <= ld_data[7:0];
            mem_hi[ld_addr] <= ld_data[15:8];
        end else begin
            if (ram_we_lo) mem_lo[ram_addr] <= ram_din[7:0];
            if (ram_we_hi) mem_hi[ram_addr] <= ram_din[15:8];
        end
        ram_q <= {mem_hi[ram_addr], mem_lo[ram_addr]};
    end

    // Reference model: pos = -1 idle, 0..3 = position inside the 4-cycle stall window.
    logic [7:0]  ref_lo [0:32767];
    logic [7:0]  ref_hi [0:32767];
    int          pos = -1;
    int          idle_cnt = MIN_GAP;
    logic [7:0]  exp_hs_dout = 8'd0;
    logic [15:0] exp_q = 16'd0;
    bit          q_valid = 1'b0;

    int          n_vec = 0;
    int          n_err = 0;
    logic        obs_ack, obs_stall;
    logic [7:0]  obs_dout;
    logic        st_log [0:19];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [14:0] e_addr;
        logic [15:0] e_din;
        logic        e_we_lo, e_we_hi;
        if (pos == 1) begin
            e_addr  = hs_addr[15:1];
            e_din   = {hs_din, hs_din};
            e_we_lo = hs_wr & ~hs_addr[0];
            e_we_hi = hs_wr & hs_addr[0];
        end else begin
            e_addr  = cpu_addr;
            e_din   = cpu_din;
            e_we_lo = (pos < 0) && cpu_we_lo;
            e_we_hi = (pos < 0) && cpu_we_hi;
        end
        check_val("cpu_stall", 32'(cpu_stall), 32'(pos >= 0));
        check_val("hs_ack", 32'(hs_ack), 32'(pos == 2));
        check_val("hs_dout", 32'(hs_dout), 32'(exp_hs_dout));
        check_val("ram_addr", 32'(ram_addr), 32'(e_addr));
        check_val("ram_din", 32'(ram_din), 32'(e_din));
        check_val("ram_we_lo", 32'(ram_we_lo), 32'(e_we_lo));
        check_val("ram_we_hi", 32'(ram_we_hi), 32'(e_we_hi));
        if (q_valid) check_val("cpu_dout", 32'(cpu_dout), 32'(exp_q));
    endtask

    task automatic model_edge();
        logic [14:0] hw;
        logic [14:0] pres;
        hw    = hs_addr[15:1];
        pres  = (pos == 1) ? hw : cpu_addr;
        exp_q = {ref_hi[pres], ref_lo[pres]};
        q_valid = 1'b1;
        if (pos == 1) begin
            if (hs_wr) begin
                if (hs_addr[0]) ref_hi[hw] = hs_din;
                else            ref_lo[hw] = hs_din;
            end else begin
                exp_hs_dout = hs_addr[0] ? ref_hi[hw] : ref_lo[hw];
            end
        end else if (pos < 0) begin
            if (cpu_we_lo) ref_lo[cpu_addr] = cpu_din[7:0];
            if (cpu_we_hi) ref_hi[cpu_addr] = cpu_din[15:8];
        end
        if (!reset_n) begin
            pos = -1;
            idle_cnt = MIN_GAP;
            exp_hs_dout = 8'd0;
        end else begin
            case (pos)
                -1: begin
                    if (idle_cnt < 1000) idle_cnt++;
                    if (hs_req && idle_cnt >= MIN_GAP) pos = 0;
                end
                0: pos = hs_req ? 1 : 3;
                1: pos = 2;
                2: pos = 3;
                default: begin
                    pos = -1;
                    idle_cnt = 0;
                end
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
        check_all();
        obs_ack   = hs_ack;
        obs_stall = cpu_stall;
        obs_dout  = hs_dout;
        @(posedge clk_sys);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic hs_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] dout);
        hs_req = 1'b1; hs_wr = wr; hs_addr = a; hs_din = d;
        lat = -1; dout = 8'd0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (obs_ack) begin
                lat = k;
                dout = obs_dout;
                break;
            end
        end
        hs_req = 1'b0;
        if (lat < 0) check_val("hs_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int          lat, acks, s1, e1, s2, e2;
        logic [7:0]  rd, orig;
        logic [15:0] d;

        // Preload RAM and reference with random data while the arbiter is held in reset.
        ld_en = 1'b1;
        for (int a = 0; a < 512; a++) begin
            d = (a == 16'h0123) ? 16'hBEEF : 16'($urandom);
            ld_addr = 15'(a); ld_data = d;
            ref_lo[a] = d[7:0]; ref_hi[a] = d[15:8];
            @(posedge clk_sys); #1;
        end
        ld_en = 1'b0;

        // Reset with a request already pending.
        hs_req = 1'b1; hs_addr = 16'h0010;
        repeat (3) begin
            step();
            check_val("rst_stall", 32'(obs_stall), 32'd0);
            check_val("rst_ack", 32'(obs_ack), 32'd0);
            check_val("rst_hs_dout", 32'(obs_dout), 32'd0);
        end
        reset_n = 1'b1;
        hs_access(1'b0, 16'h0010, 8'h00, lat, rd);
        check_val("rst_ack_latency", 32'(lat), 32'd3);

        // Byte reads from the preloaded word 0x0123.
        idle(6);
        hs_access(1'b0, 16'h0247, 8'h00, lat, rd);
        check_val("rd_hi_byte", 32'(rd), 32'h0BE);
        check_val("rd_latency", 32'(lat), 32'd3);
        idle(6);
        hs_access(1'b0, 16'h0246, 8'h00, lat, rd);
        check_val("rd_lo_byte", 32'(rd), 32'h0EF);

        // High-score write while the CPU holds a low-byte write strobe.
        idle(6);
        orig = ref_hi[15'h0080];
        cpu_addr = 15'h0080; cpu_din = 16'h1111; cpu_we_lo = 1'b1;
        hs_access(1'b1, 16'h0080, 8'h5A, lat, rd);
        idle(3);
        cpu_we_lo = 1'b0;
        idle(1);
        check_val("cw_hi_unchanged", 32'(mem_hi[15'h0080]), 32'(orig));
        check_val("cw_lo_after_release", 32'(mem_lo[15'h0080]), 32'h011);
        check_val("hs_wr_lane", 32'(mem_lo[15'h0040]), 32'h05A);

        // Back-to-back requests: 4-cycle stall, 4 idle cycles, 4-cycle stall.
        idle(6);
        hs_req = 1'b1; hs_wr = 1'b0; hs_addr = 16'h0011;
        acks = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            st_log[k] = obs_stall;
            if (obs_ack) acks++;
            if (acks == 2) hs_req = 1'b0;
        end
        s1 = 20; e1 = 20; s2 = 20; e2 = 20;
        for (int k = 0; k < 20; k++) begin
            if (s1 == 20 && st_log[k]) s1 = k;
            else if (s1 != 20 && e1 == 20 && !st_log[k]) e1 = k;
            else if (e1 != 20 && s2 == 20 && st_log[k]) s2 = k;
            else if (s2 != 20 && e2 == 20 && !st_log[k]) e2 = k;
        end
        check_val("b2b_first_window", 32'(e1 - s1), 32'd4);
        check_val("b2b_idle_gap", 32'(s2 - e1), 32'd4);
        check_val("b2b_second_window", 32'(e2 - s2), 32'd4);
        check_val("b2b_acks", 32'(acks), 32'd2);

        // Request withdrawn during STALL: no ack, no write, stall drops after two cycles.
        idle(6);
        orig = ref_hi[15'h0018];
        hs_req = 1'b1; hs_wr = 1'b1; hs_addr = 16'h0031; hs_din = 8'hC3;
        step();
        hs_req = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            st_log[k] = obs_stall;
            if (obs_ack) acks++;
        end
        check_val("abort_acks", 32'(acks), 32'd0);
        check_val("abort_stall_c1", 32'(st_log[0]), 32'd1);
        check_val("abort_stall_c2", 32'(st_log[1]), 32'd1);
        check_val("abort_stall_c3", 32'(st_log[2]), 32'd0);
        check_val("abort_no_write", 32'(mem_hi[15'h0018]), 32'(orig));

`ifdef CPU_RAM_ARB_STATS_EN
        idle(6);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check_val("stats_clr", 32'(stall_cycles), 32'd0);
        for (int n = 0; n < 10; n++) begin
            hs_access(1'b0, 16'($urandom_range(0, 31)), 8'h00, lat, rd);
            idle(6);
        end
        check_val("stats_10_access", 32'(stall_cycles), 32'd40);
`endif

        // Random traffic, including occasional resets and withdrawn requests.
        for (int n = 0; n < 1500; n++) begin
            step();
            reset_n   = ($urandom_range(0, 199) != 0);
            cpu_addr  = 15'($urandom_range(0, 15));
            cpu_din   = 16'($urandom);
            cpu_we_lo = ($urandom_range(0, 3) == 0);
            cpu_we_hi = ($urandom_range(0, 3) == 0);
            if (!hs_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    hs_req  = 1'b1;
                    hs_wr   = 1'($urandom_range(0, 1));
                    hs_addr = 16'($urandom_range(0, 31));
                    hs_din  = 8'($urandom);
                end
            end else if (obs_ack) begin
                if ($urandom_range(0, 3) != 0) hs_req = 1'b0;
            end else if (pos <= 0 && $urandom_range(0, 7) == 0) begin
                hs_req = 1'b0;
            end
        end
        reset_n = 1'b1; hs_req = 1'b0; cpu_we_lo = 1'b0; cpu_we_hi = 1'b0;
        idle(8);

        for (int a = 0; a < 512; a++) begin
            check_val($sformatf("mem_lo[%0d]", a), 32'(mem_lo[a]), 32'(ref_lo[a]));
            check_val($sformatf("mem_hi[%0d]", a), 32'(mem_hi[a]), 32'(ref_hi[a]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
